pwm_button_conditioner: RTL

Front-end stage that converts two raw, bouncing push-button inputs into clean single-cycle `increase_duty` / `decrease_duty` strobes for the PWM generator. Each channel is synchronized, debounced, edge-detected and optionally auto-repeated while held. Simultaneous requests on both channels are arbitrated so the generator never sees both strobes in one cycle. Sits directly between board buttons and `pwm_generator`.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/btn_debounce_channel.sv | 101 ++++++++++
 rtl/pwm_button_conditioner.sv | 65 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM button front end: hold-FSM encoding and default timing.
// No logic of its own; default constants assume a 100 MHz core clock.
package pwm_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;

  typedef logic [1:0] hold_state_t;

  localparam hold_state_t ST_IDLE   = 2'd0;
  localparam hold_state_t ST_HOLD   = 2'd1;
  localparam hold_state_t ST_REPEAT = 2'd2;

  typedef struct packed {
    logic inc;
    logic dec;
  } strobe_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop sync, debounce, hold/auto-repeat FSM. level_o lags raw by 2+DEBOUNCE_CYCLES;
// req_o is a combinational one-cycle request, registered by the parent; no backpressure.
module btn_debounce_channel
  import pwm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic req_o
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LIMIT  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] DELAY_LD  = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] PERIOD_LD = TMR_W'(REPEAT_PERIOD);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  hold_state_t      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             req;
  logic             tmr_expire;

  // The level only moves after the synced input has disagreed with it on
  // DEBOUNCE_CYCLES+1 consecutive samples; any agreeing sample restarts the count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LIMIT) begin
        level_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign tmr_expire = (tmr_q == TMR_ONE);

  // A zero timer never expires, which is how REPEAT_DELAY=0 disables auto-repeat.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q) begin
          req     = 1'b1;
          state_d = ST_HOLD;
          tmr_d   = DELAY_LD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!level_q) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_expire) begin
          req     = 1'b1;
          state_d = ST_REPEAT;
          tmr_d   = PERIOD_LD;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b00;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_raw_i};
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
    end
  end

  assign level_o = level_q;
  assign req_o   = req;

endmodule

// File: rtl/pwm_button_conditioner.sv
// Two debounced buttons -> arbitrated one-cycle increase/decrease strobes for pwm_generator.
// Strobe 3+DEBOUNCE_CYCLES cycles after raw press; simultaneous requests are dropped; no backpressure.
module pwm_button_conditioner
  import pwm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  output logic increase_duty,
  output logic decrease_duty,
  output logic up_level,
  output logic dn_level
);

  logic    up_req, dn_req;
  strobe_t strobe_q, strobe_d;

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn_raw_i (btn_up_raw),
    .level_o   (up_level),
    .req_o     (up_req)
  );

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dn (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn_raw_i (btn_dn_raw),
    .level_o   (dn_level),
    .req_o     (dn_req)
  );

  // Colliding requests cancel each other outright rather than being queued.
  always_comb begin
    strobe_d     = '0;
    strobe_d.inc = up_req & ~dn_req;
    strobe_d.dec = dn_req & ~up_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign increase_duty = strobe_q.inc;
  assign decrease_duty = strobe_q.dec;

endmodule
